// File: rtl/des_perm_pipe.sv
// des_perm_pipe: pipelined DES FP/IP/swap-FP/bypass permutation stream stage; `define DES_PERM_CNT_EN adds PERF_CNT
module des_perm_pipe #(
  parameter int LANES  = 1,
  parameter int STAGES = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [1:0]          IN_MODE,
  input  logic [64*LANES-1:0] IN_DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [1:0]          OUT_MODE,
  output logic [64*LANES-1:0] OUT_DATA
`ifdef DES_PERM_CNT_EN
  ,
  output logic [15:0]         PERF_CNT
`endif
);
  localparam int W = 64 * LANES;

  function automatic int fp_src(input int i);
    return (i % 8) % 2 == 0 ? 39 + 4 * (i % 8) - i / 8 : 4 * (i % 8) + 3 - i / 8;
  endfunction

  logic [W-1:0] fp_x, fp_s, ip_x, xf_d;
  logic run_q, in_fire;
  logic [STAGES-1:0] v_q, ld;
  logic [STAGES-1:0][1:0] m_q;
  logic [STAGES-1:0][W-1:0] d_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [63:0] x, sw;
    assign x  = IN_DATA[64*l +: 64];
    assign sw = {x[31:0], x[63:32]};
    for (genvar i = 0; i < 64; i++) begin : g_bit
      localparam int P = fp_src(i);
      assign fp_x[64*l+i] = x[P];
      assign fp_s[64*l+i] = sw[P];
      assign ip_x[64*l+P] = x[i];
    end
  end

  // transform selected by the incoming mode, ahead of stage 0
  always_comb xf_d = IN_MODE == 2'b00 ? fp_x : IN_MODE == 2'b01 ? ip_x : IN_MODE == 2'b10 ? IN_DATA : fp_s;

  // a stage may load when output drains or any stage at or after it is empty
  always_comb for (int s = 0; s < STAGES; s++) ld[s] = OUT_READY || !(&(v_q | STAGES'((1 << s) - 1)));

  assign IN_READY  = run_q && ld[0];
  assign in_fire   = IN_VALID && IN_READY;
  assign OUT_VALID = v_q[STAGES-1];
  assign OUT_MODE  = m_q[STAGES-1];
  assign OUT_DATA  = d_q[STAGES-1];

  // pipeline shift with bubble collapse; data only captured when a valid entry arrives
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run_q <= 1'b0;
      v_q   <= '0;
      m_q   <= '0;
      d_q   <= '0;
    end else begin
      run_q <= 1'b1;
      for (int s = 0; s < STAGES; s++) begin
        if (ld[s]) begin
          v_q[s] <= s == 0 ? in_fire : v_q[s == 0 ? 0 : s - 1];
          if (s == 0 ? in_fire : v_q[s == 0 ? 0 : s - 1]) begin
            m_q[s] <= s == 0 ? IN_MODE : m_q[s == 0 ? 0 : s - 1];
            d_q[s] <= s == 0 ? xf_d : d_q[s == 0 ? 0 : s - 1];
          end
        end
      end
    end
  end

`ifdef DES_PERM_CNT_EN
  logic [15:0] cnt_q;
  assign PERF_CNT = cnt_q;
  // saturating count of output transfers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else if (OUT_VALID && OUT_READY && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
`endif
endmodule

// File: tb/tb_des_perm_pipe.sv
// tb_des_perm_pipe: vector table, scoreboard and handshake corner cases for des_perm_pipe
module tb_des_perm_pipe;
  localparam int L = 2;
  localparam int S = 3;
  localparam int W = 64 * L;

  logic CLK = 1'b0, RST_N = 1'b1, IN_VALID = 1'b0, OUT_READY = 1'b0;
  logic IN_READY, OUT_VALID;
  logic [1:0] IN_MODE = 2'b00, OUT_MODE;
  logic [W-1:0] IN_DATA = '0, OUT_DATA;
`ifdef DES_PERM_CNT_EN
  logic [15:0] PERF_CNT;
`endif

  des_perm_pipe #(.LANES(L), .STAGES(S)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_MODE(IN_MODE), .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_MODE(OUT_MODE), .OUT_DATA(OUT_DATA)
`ifdef DES_PERM_CNT_EN
    , .PERF_CNT(PERF_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0, n_acc = 0, n_out = 0;

  typedef struct packed {logic [1:0] m; logic [W-1:0] d;} tr_t;
  tr_t q[$];
  tr_t e, last_o;
  logic stall_p = 1'b0;

  typedef struct {logic [1:0] m; logic [63:0] x; logic [63:0] y;} vec_t;
  vec_t tv[5];

  task automatic chk(input string nm, input logic [W+1:0] got, input logic [W+1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] fp64(input logic [63:0] x);
    logic [63:0] y;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        y[8*r+c] = x[(c % 2 == 0) ? 39 + 4*c - r : 4*c + 3 - r];
    return y;
  endfunction

  function automatic logic [63:0] ip64(input logic [63:0] x);
    logic [63:0] y;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        y[(c % 2 == 0) ? 39 + 4*c - r : 4*c + 3 - r] = x[8*r+c];
    return y;
  endfunction

  function automatic logic [W-1:0] perm(input logic [W-1:0] d, input logic [1:0] m);
    logic [W-1:0] o;
    logic [63:0] x;
    for (int k = 0; k < L; k++) begin
      x = d[64*k +: 64];
      o[64*k +: 64] = m == 2'b00 ? fp64(x) : m == 2'b01 ? ip64(x) : m == 2'b10 ? x : fp64({x[31:0], x[63:32]});
    end
    return o;
  endfunction

  // transfers are observed on the falling edge, ahead of the rising edge that performs them
  always @(negedge CLK) begin
    if (RST_N) begin
      if (stall_p) begin
        chk("stall_valid", {129'd0, OUT_VALID}, 130'd1);
        chk("stall_hold", {OUT_MODE, OUT_DATA}, last_o);
      end
      if (OUT_VALID && OUT_READY) begin
        n_out++;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got output %h expected none", OUT_DATA);
        end else begin
          e = q.pop_front();
          chk("sb_data", {2'b00, OUT_DATA}, {2'b00, e.d});
          chk("sb_mode", {128'd0, OUT_MODE}, {128'd0, e.m});
        end
      end
      if (IN_VALID && IN_READY) begin
        e.m = IN_MODE;
        e.d = perm(IN_DATA, IN_MODE);
        q.push_back(e);
        n_acc++;
      end
      stall_p = OUT_VALID && !OUT_READY;
      last_o  = {OUT_MODE, OUT_DATA};
    end else stall_p = 1'b0;
  end

  task automatic assert_rst();
    RST_N = 1'b0;
    q.delete();
    #1;
    chk("rst_out_valid", {129'd0, OUT_VALID}, 130'd0);
    chk("rst_out_data", {2'b00, OUT_DATA}, 130'd0);
    chk("rst_out_mode", {128'd0, OUT_MODE}, 130'd0);
    chk("rst_in_ready", {129'd0, IN_READY}, 130'd0);
`ifdef DES_PERM_CNT_EN
    chk("rst_perf_cnt", {114'd0, PERF_CNT}, 130'd0);
`endif
  endtask

  task automatic release_rst();
    @(posedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
    chk("rdy_first_edge", {129'd0, IN_READY}, 130'd0);
    @(negedge CLK);
    chk("rdy_after_release", {129'd0, IN_READY}, 130'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [W-1:0] d);
    int k;
    IN_VALID = 1'b1;
    IN_MODE  = m;
    IN_DATA  = d;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!IN_READY && k < 50);
    chk("send_accept", {129'd0, IN_READY}, 130'd1);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int k;
    OUT_READY = 1'b1;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge CLK);
      k++;
    end
    #1;
    chk("drain_empty", 130'(q.size()), 130'd0);
  endtask

  initial begin
    int t, k, n0, n1;
    logic [63:0] x;
    tv[0] = '{2'b00, 64'h0000000000000001, 64'h0200000000000000};
    tv[1] = '{2'b00, 64'h0000008000000000, 64'h0000000000000001};
    tv[2] = '{2'b01, 64'h0200000000000000, 64'h0000000000000001};
    tv[3] = '{2'b11, 64'h0000000100000000, 64'h0200000000000000};
    tv[4] = '{2'b10, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};

    #1 assert_rst();
    repeat (2) @(posedge CLK);
    release_rst();

    OUT_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      IN_VALID = 1'b1;
      IN_MODE  = tv[i].m;
      IN_DATA  = {tv[i].x, tv[i].x};
      @(negedge CLK);
      chk("tbl_in_ready", {129'd0, IN_READY}, 130'd1);
      t = cyc;
      @(posedge CLK);
      #1 IN_VALID = 1'b0;
      k = 0;
      do begin
        @(negedge CLK);
        k++;
      end while (!OUT_VALID && k < 20);
      chk("tbl_latency", 130'(cyc - t), 130'(S));
      chk("tbl_data", {2'b00, OUT_DATA}, {2'b00, tv[i].y, tv[i].y});
      chk("tbl_mode", {128'd0, OUT_MODE}, {128'd0, tv[i].m});
      @(posedge CLK);
      #1;
    end
    drain();

    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom};
      send(2'b00, {~x, x});
      send(2'b01, {fp64(~x), fp64(x)});
    end
    drain();

    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    n0 = n_acc;
    repeat (6) begin
      IN_DATA = {$urandom, $urandom, $urandom, $urandom};
      IN_MODE = 2'($urandom_range(0, 3));
      @(posedge CLK);
      #1;
    end
    chk("bp_accepts", 130'(n_acc - n0), 130'd3);
    chk("bp_full_in_ready", {129'd0, IN_READY}, 130'd0);
    n1 = n_out;
    OUT_READY = 1'b1;
    #1 chk("bp_full_drain_ready", {129'd0, IN_READY}, 130'd1);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    chk("bp_occupancy", {129'd0, OUT_VALID}, 130'd1);
    repeat (3) @(posedge CLK);
    #1;
    chk("bp_out_count", 130'(n_out - n1), 130'd4);
    chk("bp_empty", {129'd0, OUT_VALID}, 130'd0);
    drain();

    for (int i = 0; i < 10000; i++) begin
      IN_VALID  = 1'($urandom_range(0, 1));
      OUT_READY = $urandom_range(0, 3) != 0;
      IN_MODE   = 2'($urandom_range(0, 3));
      IN_DATA   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b0;
    drain();

    OUT_READY = 1'b0;
    send(2'b00, {$urandom, $urandom, $urandom, $urandom});
    send(2'b11, {$urandom, $urandom, $urandom, $urandom});
    @(posedge CLK);
    #1 chk("pre_rst_out_valid", {129'd0, OUT_VALID}, 130'd1);
    assert_rst();
    OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    release_rst();
    n1 = n_out;
    repeat (8) @(posedge CLK);
    #1;
    chk("post_rst_no_output", 130'(n_out - n1), 130'd0);
    chk("post_rst_out_valid", {129'd0, OUT_VALID}, 130'd0);

`ifdef DES_PERM_CNT_EN
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) send(2'b10, {$urandom, $urandom, $urandom, $urandom});
    repeat (4) @(posedge CLK);
    #1 chk("cnt_stall", {114'd0, PERF_CNT}, 130'd0);
    drain();
    for (int i = 0; i < 2; i++) send(2'b00, {$urandom, $urandom, $urandom, $urandom});
    drain();
    chk("cnt_five", {114'd0, PERF_CNT}, 130'd5);
    @(posedge CLK);
    #2 assert_rst();
    release_rst();
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    IN_MODE   = 2'b10;
    n0 = n_acc;
    n1 = n_out;
    k = 0;
    while (n_acc - n0 < 65540 && k < 70000) begin
      IN_DATA = {$urandom, $urandom, $urandom, $urandom};
      @(posedge CLK);
      #1;
      k++;
    end
    IN_VALID = 1'b0;
    drain();
    chk("cnt_sat_transfers", 130'(n_out - n1), 130'd65540);
    chk("cnt_saturated", {114'd0, PERF_CNT}, {114'd0, 16'hFFFF});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/des_perm_pipe.md
# des_perm_pipe

Parametrised, pipelined DES bit-permutation unit. It replaces the fixed combinational final-permutation wiring with a multi-lane stream stage that applies, per transaction, the final permutation (FP), the initial permutation (IP), a half-swap followed by FP, or a bypass. It sits between the round datapath and the block output, and between the block input and the round datapath. Valid/ready handshakes on both sides carry full backpressure.

## Interface

Parameters:
- LANES, 1: number of independent 64-bit blocks per transaction.
- STAGES, 2: pipeline register depth. Legal range 1..4.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  input transaction present.
- IN_READY  output  1  unit accepts the input this cycle.
- IN_MODE  input  2  transform select: 00 FP, 01 IP, 10 bypass, 11 swap-then-FP.
- IN_DATA  input  64*LANES  lane k occupies bits [64k+63:64k].
- OUT_VALID  output  1  output transaction present.
- OUT_READY  input  1  downstream accepts the output.
- OUT_MODE  output  2  IN_MODE that travelled with the transaction.
- OUT_DATA  output  64*LANES  transformed lanes.
- PERF_CNT  output  16  completed-transaction count. Present only with DES_PERM_CNT_EN.

## Operation

- Bit 0 is the LSB throughout.
- FP: for r,c in 0..7, out[8r+c] = in[(c even ? 39+4c : 4c+3) − r]. Example: out[0]=in[39], out[57]=in[0].
- IP: exact inverse of FP, so IP(FP(x)) = x.
- Swap-then-FP: FP applied to {in[31:0], in[63:32]}.
- Bypass: out = in.
- Every lane is transformed independently with the same mode.
- The transform is combinational ahead of stage 0. Stages 1..STAGES−1 carry data unchanged.
- Each stage holds valid, mode and data.
- A transfer occurs on a side when VALID && READY at a rising edge.
- Stage s loads from s−1 when s is empty or s advances. The last stage advances on OUT_READY.
- IN_READY = run && (stage 0 empty || stage 0 advances). This is combinational from state and OUT_READY.
- run is a register, cleared by reset and set on the first CLK edge with RST_N high.
- OUT_VALID and OUT_DATA/OUT_MODE come straight from the last stage.
- OUT_DATA/OUT_MODE stay stable while OUT_VALID && !OUT_READY.

## Timing

- Reset values: all stage valids 0, data 0, mode 00, OUT_VALID 0, OUT_DATA 0, OUT_MODE 00, PERF_CNT 0, run 0.
- IN_READY is 0 while RST_N is low and during the first edge after release. From the second edge it is 1 while the pipeline is empty.
- Latency: input accepted at edge N gives OUT_VALID high after edge N+STAGES−1, i.e. STAGES cycles of register delay.
- Throughput: one transaction per cycle with OUT_READY held high.
- Full: all STAGES valid and OUT_READY low makes IN_READY 0. No transaction is lost or duplicated.
- Simultaneous accept and emit when full with OUT_READY high: both transfer in the same cycle, and occupancy is unchanged.
- Bubbles collapse. An empty stage loads even when the downstream stage is stalled.
- Reset mid-operation: all in-flight transactions are discarded immediately (asynchronous), and outputs take their reset values.
- IN_MODE is sampled only on an input transfer. It is ignored otherwise.

## Configuration

- DES_PERM_CNT_EN defined:
  - PERF_CNT port exists.
  - It increments by 1 on each output transfer.
  - It saturates at 16'hFFFF.
  - It resets to 0.
- DES_PERM_CNT_EN undefined:
  - The port and counter logic are absent.
  - All other behaviour is identical.

## Test plan

- FP with LANES=1, STAGES=2: IN_DATA 64'h0000000000000001, mode 00 → OUT_DATA 64'h0200000000000000, 2 cycles after accept. Input 64'h0000008000000000 → 64'h0000000000000001.
- IP round trip: feed 64'h0200000000000000 with mode 01 → 64'h0000000000000001. Then 1000 random x: FP then IP returns x.
- Swap-then-FP: 64'h0000000100000000, mode 11 → 64'h0200000000000000. Bypass of 64'h0123456789ABCDEF, mode 10 → unchanged. OUT_MODE matches each input's mode.
- Backpressure with STAGES=3, LANES=2:
  - Stream with IN_VALID high and OUT_READY low for 6 cycles: exactly 3 accepts, then IN_READY low.
  - Release OUT_READY: outputs appear in order with no gaps or duplicates.
  - Randomised VALID/READY on both sides for 10k cycles against a scoreboard.
- Reset mid-stream: assert RST_N low with 2 transactions in flight. OUT_VALID falls immediately and nothing emerges after release. IN_READY goes high one edge after release.
- With DES_PERM_CNT_EN:
  - 5 output transfers → PERF_CNT = 5.
  - Stalled cycles do not count.
  - Force 65540 transfers → PERF_CNT holds 16'hFFFF.
